// File: rtl/periph_arb_pkg.sv
// Shared types and helpers for the cluster peripheral round-robin arbiter.
package periph_arb_pkg;

  localparam int unsigned MAX_NB_REQ              = 32;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  localparam int unsigned IDX_MAX_W = idx_w(MAX_NB_REQ);

  typedef logic [IDX_MAX_W-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } pick_t;

  typedef enum logic {
    ST_FREE,
    ST_LOCKED
  } arb_state_e;

  // First asserted request at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_NB_REQ-1:0] req,
                                    input int unsigned n,
                                    input int unsigned ptr);
    pick_t p;
    int unsigned k;
    p = '0;
    for (int unsigned i = 0; i < MAX_NB_REQ; i++) begin
      k = (ptr + i) % n;
      if ((i < n) && !p.valid && req[idx_t'(k)]) begin
        p.valid = 1'b1;
        p.idx   = idx_t'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/periph_rr_arbiter_if.sv
// Master-side request/response bundle plus the single peripheral-side port.
interface periph_rr_arbiter_if #(
  parameter int unsigned NB_REQ     = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
  logic [NB_REQ-1:0]                 req_i;
  logic [NB_REQ-1:0][ADDR_WIDTH-1:0] add_i;
  logic [NB_REQ-1:0]                 wen_i;
  logic [NB_REQ-1:0][5:0]            atop_i;
  logic [NB_REQ-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NB_REQ-1:0][BE_WIDTH-1:0]   be_i;
  logic [NB_REQ-1:0]                 gnt_o;
  logic [NB_REQ-1:0]                 r_valid_o;
  logic [NB_REQ-1:0]                 r_opc_o;
  logic [DATA_WIDTH-1:0]             r_rdata_o;

  logic                              req_o;
  logic [ADDR_WIDTH-1:0]             add_o;
  logic                              wen_o;
  logic [5:0]                        atop_o;
  logic [DATA_WIDTH-1:0]             wdata_o;
  logic [BE_WIDTH-1:0]               be_o;
  logic                              gnt_i;
  logic                              r_valid_i;
  logic                              r_opc_i;
  logic [DATA_WIDTH-1:0]             r_rdata_i;

  // Arbiter view.
  modport slave (
    input  req_i, add_i, wen_i, atop_i, wdata_i, be_i,
    input  gnt_i, r_valid_i, r_opc_i, r_rdata_i,
    output gnt_o, r_valid_o, r_opc_o, r_rdata_o,
    output req_o, add_o, wen_o, atop_o, wdata_o, be_o
  );

  // Environment view: masters plus peripheral side.
  modport master (
    output req_i, add_i, wen_i, atop_i, wdata_i, be_i,
    output gnt_i, r_valid_i, r_opc_i, r_rdata_i,
    input  gnt_o, r_valid_o, r_opc_o, r_rdata_o,
    input  req_o, add_o, wen_o, atop_o, wdata_o, be_o
  );
endinterface

// File: rtl/periph_arb_id_fifo.sv
// In-flight winner-ID queue; head is registered storage, no fall-through.
module periph_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_cnt == CNT_W'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral port among NB_REQ masters, with in-order response steering.
module periph_rr_arbiter
  import periph_arb_pkg::*;
#(
  parameter int unsigned NB_REQ          = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  periph_rr_arbiter_if.slave  bus,
  output logic                err_o
);
  localparam int unsigned IDX_W = idx_w(NB_REQ);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_ptr_nxt;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] w_lock_idx_nxt;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_head;
  logic             r_err;
  pick_t            w_pick;
  logic             w_req_any;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_pick    = rr_pick(MAX_NB_REQ'(bus.req_i), NB_REQ, 32'(r_rr_ptr));
  assign w_req_any = w_pick.valid & (w_pick.idx < IDX_MAX_W'(NB_REQ));
  assign w_winner  = (r_state == ST_LOCKED) ? r_lock_idx : IDX_W'(w_pick.idx);

  // Issue side: a full queue blocks, independent of any same-cycle response.
  assign bus.req_o   = w_req_any & ~w_full & rst_ni;
  assign bus.add_o   = bus.add_i[w_winner];
  assign bus.wen_o   = bus.wen_i[w_winner];
  assign bus.atop_o  = bus.atop_i[w_winner];
  assign bus.wdata_o = bus.wdata_i[w_winner];
  assign bus.be_o    = bus.be_i[w_winner];

  assign w_push = bus.req_o & bus.gnt_i;
  assign w_pop  = bus.r_valid_i & ~w_empty & rst_ni;

  assign bus.r_rdata_o = bus.r_rdata_i;
  assign err_o         = r_err;

  periph_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_winner),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    bus.gnt_o     = '0;
    bus.r_valid_o = '0;
    bus.r_opc_o   = '0;
    if (w_push) begin
      bus.gnt_o[w_winner] = 1'b1;
    end
    if (w_pop) begin
      bus.r_valid_o[w_head] = 1'b1;
      bus.r_opc_o[w_head]   = bus.r_opc_i;
    end
  end

  // Lock holds an un-granted selection; a grant releases it and rotates priority.
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_lock_idx_nxt = r_lock_idx;
    if (w_push) begin
      w_state_nxt  = ST_FREE;
      w_rr_ptr_nxt = (w_winner == IDX_W'(NB_REQ - 1)) ? '0 : w_winner + IDX_W'(1);
    end else if (bus.req_o) begin
      w_state_nxt    = ST_LOCKED;
      w_lock_idx_nxt = w_winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_FREE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end

  // Sticky: a response with nothing in flight can only be a protocol violation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (bus.r_valid_i && w_empty) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Directed plus randomized checks of periph_rr_arbiter against a queue-based reference model.
module tb_periph_rr_arbiter;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MO = 4;

  logic clk;
  logic rst_n;
  logic err_o;

  periph_rr_arbiter_if #(.NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  periph_rr_arbiter #(
    .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] m_add   [NB];
  logic          m_wen   [NB];
  logic [5:0]    m_atop  [NB];
  logic [DW-1:0] m_wdata [NB];
  logic [BW-1:0] m_be    [NB];

  int mdl_ptr;
  bit mdl_lock;
  int mdl_lock_idx;
  int idq[$];
  bit mdl_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields(input int i);
    m_add[i]   = $urandom;
    m_wen[i]   = 1'($urandom);
    m_atop[i]  = 6'($urandom);
    m_wdata[i] = $urandom;
    m_be[i]    = 4'($urandom);
  endtask

  function automatic int mdl_winner(input logic [NB-1:0] req);
    if (mdl_lock) return mdl_lock_idx;
    for (int i = 0; i < NB; i++) begin
      if (req[(mdl_ptr + i) % NB]) return (mdl_ptr + i) % NB;
    end
    return -1;
  endfunction

  // One clock: drive, check combinational outputs against the model, advance the model.
  task automatic cycle(input logic rst, input logic [NB-1:0] req, input logic gnt,
                       input logic rv, input logic opc, output int gidx);
    int  w;
    bit  ereq;
    bit  pop_ok;
    logic [NB-1:0] egnt;
    logic [NB-1:0] erv;
    logic [NB-1:0] eopc;
    logic [DW-1:0] rdata;
    rdata = $urandom;
    rst_n = rst;
    bus.req_i = req;
    for (int i = 0; i < NB; i++) begin
      bus.add_i[i]   = m_add[i];
      bus.wen_i[i]   = m_wen[i];
      bus.atop_i[i]  = m_atop[i];
      bus.wdata_i[i] = m_wdata[i];
      bus.be_i[i]    = m_be[i];
    end
    bus.gnt_i     = gnt;
    bus.r_valid_i = rv;
    bus.r_opc_i   = opc;
    bus.r_rdata_i = rdata;
    #1;
    w      = mdl_winner(req);
    ereq   = rst && (req != '0) && (idq.size() < MO);
    egnt   = (ereq && gnt) ? NB'(1 << w) : '0;
    pop_ok = rst && rv && (idq.size() > 0);
    erv    = pop_ok ? NB'(1 << idq[0]) : '0;
    eopc   = (pop_ok && opc) ? NB'(1 << idq[0]) : '0;
    chk("req_o", 64'(bus.req_o), 64'(ereq));
    chk("gnt_o", 64'(bus.gnt_o), 64'(egnt));
    chk("r_valid_o", 64'(bus.r_valid_o), 64'(erv));
    chk("r_opc_o", 64'(bus.r_opc_o), 64'(eopc));
    chk("r_rdata_o", 64'(bus.r_rdata_o), 64'(rdata));
    chk("err_o", 64'(err_o), 64'(mdl_err));
    if (ereq) begin
      chk("add_o", 64'(bus.add_o), 64'(m_add[w]));
      chk("wen_o", 64'(bus.wen_o), 64'(m_wen[w]));
      chk("atop_o", 64'(bus.atop_o), 64'(m_atop[w]));
      chk("wdata_o", 64'(bus.wdata_o), 64'(m_wdata[w]));
      chk("be_o", 64'(bus.be_o), 64'(m_be[w]));
    end
    @(posedge clk);
    gidx = (ereq && gnt) ? w : -1;
    if (!rst) begin
      mdl_ptr  = 0;
      mdl_lock = 0;
      idq.delete();
      mdl_err  = 0;
    end else begin
      if (pop_ok) void'(idq.pop_front());
      else if (rv) mdl_err = 1;
      if (ereq && gnt) begin
        idq.push_back(w);
        mdl_ptr  = (w + 1) % NB;
        mdl_lock = 0;
      end else if (ereq) begin
        mdl_lock     = 1;
        mdl_lock_idx = w;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    int g;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, g);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, g);
  endtask

  task automatic drain();
    int g;
    for (int i = 0; i < 2 * MO && idq.size() > 0; i++) begin
      cycle(1'b1, '0, 1'b0, 1'b1, 1'($urandom), g);
    end
  endtask

  initial begin
    int g;
    int n;
    int exp_order[5];
    logic [NB-1:0] pend;
    exp_order = '{0, 1, 2, 3, 0};
    mdl_ptr = 0; mdl_lock = 0; mdl_err = 0; mdl_lock_idx = 0;
    for (int i = 0; i < NB; i++) rand_fields(i);

    // Reset state and full-request rotation with responses two cycles behind.
    do_reset();
    chk("reset_err", 64'(err_o), 64'(0));
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 4'hF, 1'b1, 1'(c >= 2), 1'($urandom), g);
      chk("t1_order", 64'(g), 64'(exp_order[c]));
    end
    drain();

    // Stalled selection stays on master 2 after master 0 joins.
    do_reset();
    for (int c = 0; c < 3; c++) cycle(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, g);
    cycle(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, g);
    chk("t2_stall", 64'(g), 64'(-1));
    cycle(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, g);
    chk("t2_first", 64'(g), 64'(2));
    cycle(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, g);
    chk("t2_next", 64'(g), 64'(0));
    drain();

    // Queue-full blocking; a same-cycle pop does not unblock.
    do_reset();
    n = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, g);
      if (g >= 0) n++;
    end
    chk("t3_grants", 64'(n), 64'(MO));
    cycle(1'b1, 4'hF, 1'b1, 1'b1, 1'b0, g);
    chk("t3_pop_cycle", 64'(g), 64'(-1));
    cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, g);
    chk("t3_resume", 64'(g), 64'(0));
    drain();

    // Response with empty queue sets a sticky error.
    do_reset();
    cycle(1'b1, '0, 1'b0, 1'b1, 1'b1, g);
    for (int c = 0; c < 3; c++) cycle(1'b1, '0, 1'b0, 1'b0, 1'b0, g);
    chk("t5_sticky", 64'(err_o), 64'(1));
    do_reset();
    chk("t5_cleared", 64'(err_o), 64'(0));

    // Reset with three in flight; stale response afterwards is an error.
    for (int c = 0; c < 3; c++) cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, g);
    chk("t6_inflight", 64'(idq.size()), 64'(3));
    cycle(1'b0, 4'hF, 1'b1, 1'b1, 1'b1, g);
    chk("t6_no_grant", 64'(g), 64'(-1));
    cycle(1'b1, '0, 1'b0, 1'b1, 1'b0, g);
    chk("t6_stale_err", 64'(err_o), 64'(1));
    cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, g);
    chk("t6_ptr_zero", 64'(g), 64'(0));
    drain();

    // Randomized traffic with masters holding requests until granted.
    do_reset();
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          rand_fields(i);
        end
      end
      cycle(($urandom % 100) != 0, pend, ($urandom % 4) != 0,
            (idq.size() > 0) && ($urandom % 2 == 0), 1'($urandom), g);
      if (g >= 0) pend[g] = 1'b0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_rr_arbiter.md
# periph_rr_arbiter

Round-robin arbiter that shares one cluster peripheral request port among `NB_REQ` masters (cores, DMA, HWPE) in front of the peripheral request FIFO. Requests follow a req/gnt handshake with an in-order, single-beat `r_valid` response. The block records the winner index of every accepted transaction in an in-flight ID queue. Each response is steered back to its originating master.

## Interface
Parameters:
- `NB_REQ`, 4: number of requesting masters (≥2)
- `ADDR_WIDTH`, 32: address width
- `DATA_WIDTH`, 32: data width
- `BE_WIDTH`, `DATA_WIDTH/8`: byte-enable width
- `MAX_OUTSTANDING`, 4: depth of the in-flight ID queue (power of 2, ≥2)

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; synchronous, active-low
- `req_i`  in  `NB_REQ`  per-master request
- `add_i`  in  `NB_REQ`×`ADDR_WIDTH`  per-master address
- `wen_i`  in  `NB_REQ`  per-master write-enable (1 = read, 0 = write)
- `atop_i`  in  `NB_REQ`×6  per-master atomic opcode
- `wdata_i`  in  `NB_REQ`×`DATA_WIDTH`  per-master write data
- `be_i`  in  `NB_REQ`×`BE_WIDTH`  per-master byte enables
- `gnt_o`  out  `NB_REQ`  per-master grant
- `r_valid_o`  out  `NB_REQ`  per-master response valid
- `r_opc_o`  out  `NB_REQ`  per-master response error/opcode
- `r_rdata_o`  out  `DATA_WIDTH`  read data, broadcast to all masters
- `req_o`  out  1  request to peripheral side
- `add_o`  out  `ADDR_WIDTH`  forwarded field of the selected master
- `wen_o`  out  1  forwarded field of the selected master
- `atop_o`  out  6  forwarded field of the selected master
- `wdata_o`  out  `DATA_WIDTH`  forwarded field of the selected master
- `be_o`  out  `BE_WIDTH`  forwarded field of the selected master
- `gnt_i`  in  1  grant from peripheral side
- `r_valid_i`  in  1  response from peripheral side
- `r_opc_i`  in  1  response from peripheral side
- `r_rdata_i`  in  `DATA_WIDTH`  response from peripheral side
- `err_o`  out  1  sticky protocol error

## Operation
State:
- `rr_ptr`: highest-priority index.
- `lock`, `lock_idx`: pending un-granted selection.
- ID queue: read/write pointers and count.
- `err` flag.

Arbitration:
- When `lock` = 0, the winner is the first asserted `req_i[k]` scanning from `rr_ptr` upward, modulo `NB_REQ`.
- When `lock` = 1, the winner is `lock_idx`.

Issue rules:
- `req_o = |req_i & !full & rst_ni`.
- `add_o` and the other forwarded fields are muxed from the winner.
- `gnt_o[winner] = gnt_i & req_o`. All other bits of `gnt_o` are 0.

Handshake (`req_o & gnt_i`):
- Push the winner into the ID queue.
- Set `rr_ptr ← (winner+1) mod NB_REQ`.
- Clear `lock`.

Stall without grant:
- `req_o & !gnt_i` sets `lock` = 1 and `lock_idx` = winner.
- Masters hold requests stable until granted. The selection never changes while un-granted.

Full queue:
- When count = `MAX_OUTSTANDING`, `req_o` = 0 and no grant is issued.
- A pop in the same cycle does not unblock. Issue resumes the next cycle.

Response routing:
- `r_valid_i` pops the queue head `h`.
- `r_valid_o[h] = r_valid_i`. All other bits of `r_valid_o` are 0.
- `r_opc_o[h] = r_opc_i`. All other bits of `r_opc_o` are 0.

Push and pop:
- Simultaneous push and pop is legal: count is unchanged and both pointers advance.
- Pointers wrap modulo `MAX_OUTSTANDING`.

Error:
- `r_valid_i` with an empty queue, and no push in the same cycle, sets `err` = 1.
- The response is dropped and nothing is routed.
- `err` stays set until reset.
- A push and a `r_valid_i` in the same cycle on an empty queue is an error, because responses are never same-cycle.

Reset (`rst_ni` = 0 at a clock edge):
- `rr_ptr` = 0, `lock` = 0, queue empty, `err` = 0.
- While `rst_ni` is low, `req_o`, `gnt_o`, `r_valid_o` and `r_opc_o` are 0.
- Reset mid-operation discards all in-flight IDs. Later responses raise `err`.

## Timing
- Request path is combinational, 0 cycles: `req_i` → `req_o`, and `gnt_i` → `gnt_o`.
- Response path is combinational, 0 cycles: `r_valid_i` → `r_valid_o`.
- Arbitration state, queue pointers and `err` update on the rising edge after the handshake or response.
- No combinational path from `r_valid_i` to `req_o`.
- Responses arrive at least 1 cycle after their grant, in order.
- Throughput is 1 transaction per cycle while the queue is not full.

## Structure
- Package `periph_arb_pkg` holds:
  - `idx_t` index type, derived with a `NB_REQ`-parameterised function `$clog2`.
  - A default `MAX_OUTSTANDING` constant.
  - The round-robin pick function: `(req vector, ptr) → idx, valid`.
- Sub-module `periph_arb_id_fifo`:
  - Sync-reset, fall-through-free ID queue.
  - Ports: push, pop, `data_i`, `data_o`, `full_o`, `empty_o`.
- The top level contains the arbitration logic, the lock register and the muxes.

## Test plan
- `NB_REQ`=4, all `req_i` = 1111, `gnt_i` always 1 → grants to 0,1,2,3,0 on consecutive cycles. `r_valid_i` 2 cycles later routes to the same sequence.
- `req_i[2]` asserted, `gnt_i` = 0 for 3 cycles, then `req_i[0]` also asserted → `add_o` stays on master 2 until `gnt_i`. Master 0 is granted next.
- `gnt_i` = 1, no responses, `MAX_OUTSTANDING`=4 → exactly 4 grants, then `req_o` = 0. One `r_valid_i` → `req_o` returns the following cycle.
- Push and pop in the same cycle at count 2 → count stays 2. A pop wrap from index 3 to 0 routes correctly.
- `r_valid_i` with an empty queue → no `r_valid_o` bit set, `err_o` = 1, and it stays 1 until `rst_ni` is low.
- Synchronous reset with 3 transactions in flight → all outputs are 0 during reset. After reset, `rr_ptr` is 0 and a stale response sets `err_o`.
